// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register between N requesters.
// Each grant loads the winner's data, then locks the register for HOLD cycles.
module shared_reg_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     wr_data,
    output logic [N-1:0]           gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy
);

    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] PTR_RST = PW'(N - 1);
    localparam logic [3:0]    HOLD_LD = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;
    localparam logic          HOLD_EN = (HOLD > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [N-1:0]       gnt_r;
    logic [N-1:0]       gnt_nxt_s;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   q_nxt_s;
    logic               q_valid_r;
    logic               q_valid_nxt_s;
    logic [PW-1:0]      owner_r;
    logic [PW-1:0]      owner_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic [PW-1:0]      ptr_r;
    logic [PW-1:0]      ptr_nxt_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_nxt_s;
    logic [PW-1:0]      cand_s;
    logic [PW-1:0]      win_idx_s;
    logic               win_found_s;
    logic [WIDTH-1:0]   owner_data_s;

    function automatic logic [N-1:0] onehot_f(input logic [PW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first requester after ptr, wrapping modulo N.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= N; k++) begin
            cand_s = PW'((int'(ptr_r) + k) % N);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Data of the requester currently holding the grant.
    always_comb begin
        owner_data_s = wr_data[owner_r*WIDTH +: WIDTH];
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_nxt_s   = state_r;
        gnt_nxt_s     = '0;
        q_nxt_s       = q_r;
        q_valid_nxt_s = q_valid_r;
        owner_nxt_s   = owner_r;
        ptr_nxt_s     = ptr_r;
        cnt_nxt_s     = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_nxt_s = ST_GRANT;
                    gnt_nxt_s   = onehot_f(win_idx_s);
                    owner_nxt_s = win_idx_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A withdrawn request aborts without touching q or the pointer.
                if (req[owner_r]) begin
                    q_nxt_s       = owner_data_s;
                    q_valid_nxt_s = 1'b1;
                    ptr_nxt_s     = owner_r;
                    if (HOLD_EN) begin
                        state_nxt_s = ST_HOLD;
                        cnt_nxt_s   = HOLD_LD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE) ? 1'b1 : 1'b0;
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            gnt_r     <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            owner_r   <= '0;
            busy_r    <= 1'b0;
            ptr_r     <= PTR_RST;
            cnt_r     <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            gnt_r     <= gnt_nxt_s;
            q_r       <= q_nxt_s;
            q_valid_r <= q_valid_nxt_s;
            owner_r   <= owner_nxt_s;
            busy_r    <= busy_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign gnt     = gnt_r;
    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign owner   = owner_r;
    assign busy    = busy_r;

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit bank of D flip-flops (the shared register) between N requesters. Each requester raises a request with its write data. The block grants one requester at a time, loads that requester's data into the register, then locks the register for HOLD cycles before the next arbitration. It sits between several producer blocks and a single storage register they cannot drive directly.

## Interface
- N, default 4: number of requesters (2..8)
- WIDTH, default 8: width of the shared register
- HOLD, default 2: lock cycles after each write (0..15)

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset, acts immediately, independent of clk)
- req  in  N  request per requester, level-sensitive
- wr_data  in  N*WIDTH  requester i's data on bits [i*WIDTH +: WIDTH]
- gnt  out  N  one-hot grant, high for exactly one cycle per grant, registered
- q  out  WIDTH  shared register contents
- q_valid  out  1  high once any write has completed since reset
- owner  out  clog2(N)  index of last granted requester
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, GRANT, HOLD.
- IDLE, req == 0: stay in IDLE.
- IDLE, req != 0: pick a winner by round-robin.
  - Search starts at ptr+1 and wraps modulo N; the first set bit wins.
  - Next state is GRANT. gnt <= onehot(winner), owner <= winner.
- GRANT, req[owner] == 1:
  - q <= wr_data[owner], q_valid <= 1, ptr <= owner.
  - Next state is HOLD with cnt <= HOLD-1, or IDLE if HOLD == 0.
- GRANT, req[owner] == 0 (requester withdrew): abort.
  - q, q_valid and ptr are unchanged. Next state is IDLE.
- HOLD: cnt decrements each cycle. When cnt == 0, next state is IDLE.
- gnt clears when leaving GRANT. gnt is never high outside GRANT.
- Requester contract:
  - Hold req and wr_data stable until it sees gnt.
  - wr_data is sampled only in the GRANT cycle.
  - Drop req in the cycle after gnt unless it wants another write.
- Requests arriving during GRANT or HOLD are not lost. They are arbitrated on the next IDLE cycle.
- Fairness: a continuously requesting requester is granted within N arbitration rounds.
- Reset (rst = 0, asynchronous, also mid-operation):
  - state = IDLE, gnt = 0, q = 0, q_valid = 0, owner = 0, busy = 0, cnt = 0.
  - ptr = N-1, so requester 0 has first priority after reset.
  - Any in-flight grant is discarded.
- Reset release: synchronous deassertion is the integrator's job. The block's first active edge is the first rising clk with rst = 1.

## Timing
- Cycle 0: IDLE with req != 0. Cycle 1: gnt high, busy high. Cycle 2: q holds the new data, q_valid = 1.
- Request-to-grant latency: 1 cycle from IDLE.
- Grant-to-data latency: 1 cycle.
- Arbitration period with continuous requests: HOLD+2 cycles. With HOLD = 2, grants land at cycles 1, 5, 9, …
- busy is high from cycle 1 through cycle 1+HOLD inclusive. It drops in the IDLE cycle that re-arbitrates.
- owner and q change only on rising clk edges. The only asynchronous transition is reset.

## Test plan
- Reset/idle:
  - rst = 0 with random inputs: all outputs 0, no gnt.
  - Release reset, req = 0 for 10 cycles: busy = 0, q = 0 throughout.
- Single write (N=4, WIDTH=8, HOLD=2):
  - req = 4'b0100 with wr_data[2] = 8'hA5 at cycle 0.
  - Expect gnt = 4'b0100 in cycle 1; q = 8'hA5, q_valid = 1, owner = 2 in cycle 2.
  - busy high in cycles 1-3.
- Round-robin:
  - req = 4'b1111 held, data = index+8'h10.
  - Grants in order 0, 1, 2, 3, 0 at cycles 1, 5, 9, 13, 17.
  - q follows 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
- Abort:
  - req[1] rises in cycle 0 and drops in cycle 1 while gnt[1] is high.
  - Expect q unchanged, q_valid unchanged, IDLE in cycle 2.
  - A subsequent req = 4'b0011 still grants requester 0 first, because ptr is unchanged.
- HOLD = 0 variant:
  - req = 4'b0011 held: grants alternate 0, 1 every 2 cycles.
  - busy high in GRANT cycles only.
- Mid-operation reset:
  - Assert rst = 0 asynchronously between edges during HOLD.
  - Outputs clear immediately, without waiting for an edge.
  - After release, req = 4'b1000 then 4'b1001: requester 0 wins first.
